// File: rtl/l_lock_pkg.sv
// Shared types and constants for the lock's BCD/binary conversion paths.
package l_lock_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
    localparam int         BIN_MAX       = 1023;
    localparam int         ACC_W         = 14;

    // A nibble is a legal BCD digit when it does not exceed nine.
    function automatic logic bcd_digit_ok(input logic [3:0] digit);
        return (digit <= BCD_DIGIT_MAX);
    endfunction

endpackage

// File: rtl/l_16bit_to_10_if.sv
// Start/done handshake and result bus between keypad entry and the converter.
interface l_16bit_to_10_if #(
    parameter int DIGITS = 4,
    parameter int OUT_W  = 10
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [OUT_W-1:0]      bin_out;
    logic                  err_digit;
    logic                  err_range;

    modport master (
        output start, bcd_in,
        input  busy, done, bin_out, err_digit, err_range
    );

    modport slave (
        input  start, bcd_in,
        output busy, done, bin_out, err_digit, err_range
    );
endinterface

// File: rtl/l_bcd_mac10.sv
// One decimal step of the BCD-to-binary conversion: acc*10 + digit, plus digit legality.
module l_bcd_mac10
    import l_lock_pkg::*;
#(
    parameter int W = ACC_W
) (
    input  logic [W-1:0] acc_i,
    input  logic [3:0]   digit_i,
    output logic [W-1:0] acc_o,
    output logic         digit_ok_o
);

    // Multiply by ten as (x<<3)+(x<<1); an illegal digit still feeds the sum.
    always_comb begin
        acc_o      = (acc_i << 3) + (acc_i << 1) + {{(W-4){1'b0}}, digit_i};
        digit_ok_o = bcd_digit_ok(digit_i);
    end

endmodule

// File: rtl/l_16bit_to_10.sv
// Sequential packed-BCD to binary converter, one digit per clock, MSD first,
// with saturation above the output range and rejection of non-decimal nibbles.
module l_16bit_to_10
    import l_lock_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int OUT_W  = 10
) (
    input  logic           clk,
    input  logic           rst,
    l_16bit_to_10_if.slave bus
);

    localparam int                 IN_W     = 4 * DIGITS;
    localparam int                 IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [ACC_W-1:0]   SAT_ACC  = ACC_W'((1 << OUT_W) - 1);
    localparam logic [OUT_W-1:0]   SAT_BIN  = {OUT_W{1'b1}};

    state_t             state_q, state_d;
    logic [IN_W-1:0]    shift_q, shift_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               bad_q, bad_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [OUT_W-1:0]   bin_q, bin_d;
    logic               err_digit_q, err_digit_d;
    logic               err_range_q, err_range_d;

    logic [ACC_W-1:0]   mac_acc_s;
    logic               mac_ok_s;

    l_bcd_mac10 #(.W(ACC_W)) u_mac (
        .acc_i      (acc_q),
        .digit_i    (shift_q[IN_W-1 -: 4]),
        .acc_o      (mac_acc_s),
        .digit_ok_o (mac_ok_s)
    );

    // Next-state, datapath and result selection; results resolve on the last digit
    // so they are registered on the same edge that enters DONE.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        bad_d       = bad_q;
        bin_d       = bin_q;
        err_digit_d = err_digit_q;
        err_range_d = err_range_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CONV;
                    shift_d = bus.bcd_in;
                    acc_d   = '0;
                    idx_d   = '0;
                    bad_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                acc_d   = mac_acc_s;
                bad_d   = bad_q | ~mac_ok_s;
                shift_d = {shift_q[IN_W-5:0], 4'h0};
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    if (bad_d) begin
                        bin_d       = '0;
                        err_digit_d = 1'b1;
                        err_range_d = 1'b0;
                    end else if (mac_acc_s > SAT_ACC) begin
                        bin_d       = SAT_BIN;
                        err_digit_d = 1'b0;
                        err_range_d = 1'b1;
                    end else begin
                        bin_d       = mac_acc_s[OUT_W-1:0];
                        err_digit_d = 1'b0;
                        err_range_d = 1'b0;
                    end
                end else begin
                    state_d = CONV;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == CONV);
        done_d = (state_d == DONE);
    end

    // State and output registers; reset aborts any conversion in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            bad_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bin_q       <= '0;
            err_digit_q <= 1'b0;
            err_range_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            bad_q       <= bad_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bin_q       <= bin_d;
            err_digit_q <= err_digit_d;
            err_range_q <= err_range_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.bin_out   = bin_q;
    assign bus.err_digit = err_digit_q;
    assign bus.err_range = err_range_q;

endmodule
